// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle HI/LO multiply/divide unit that sits beside the CPU ALU.
// It multiplies with shift-add and divides with a restoring algorithm, one bit per
// cycle, and it owns the HI/LO registers. While a multiply or divide is running, no
// new op is accepted, so MFHI/MFLO issue stalls until the result is ready.
// Build option: define MULDIV_SIGNED_EN so that MULT/DIV (18/1A) run signed, using
// the operand magnitudes plus a sign fixup at the end. When the macro is not defined,
// MULT/DIV behave exactly like MULTU/DIVU and no sign logic is built.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    // Control and architectural state (async reset)
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;

    // Datapath working registers. These carry no reset because they are always
    // loaded when an op is accepted.
    // acc holds the product during MUL ({upper sum, remaining multiplier bits}).
    // During DIV it holds {remainder, quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;   // multiplicand or divisor magnitude

    // Operand magnitudes as they are latched on accept
    logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef MULDIV_SIGNED_EN
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;   // negate product / quotient
    logic               neg_rem_q, neg_rem_d;   // remainder follows dividend sign
    logic               op_signed;
    logic               a_neg, b_neg;
    logic signed [WIDTH-1:0] a_s, b_s;

    // Two's-complement negation when the flag is set. Everything wraps modulo 2^N.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v,
                                                         input logic n);
        return n ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    // Signed operand decode and the magnitudes derived from it
    always_comb begin
        op_signed = (funct == F_MULT) || (funct == F_DIV);
        a_s       = a;
        b_s       = b;
        a_neg     = op_signed && (a_s < 0);
        b_neg     = op_signed && (b_s < 0);
        a_mag     = cond_neg(a, a_neg);
        b_mag     = cond_neg(b, b_neg);
    end
`else
    // In the unsigned build the raw operands are the magnitudes
    always_comb begin
        a_mag = a;
        b_mag = b;
    end
`endif

    // One shift-add multiply step. The add is one bit wider than WIDTH so its carry
    // shifts down into the product.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    // One restoring divide step on the shifted {rem,quo}. A remainder shifted left can
    // need WIDTH+1 bits, so the trial subtract is WIDTH+1 bits wide.
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_next;

    // Datapath step results for the MUL and DIV states
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, dsr_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, dsr_q};
        div_ok   = ~div_diff[WIDTH];
        div_next = {(div_ok ? div_diff[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1]),
                    acc_q[WIDTH-2:0], div_ok};
    end

    // Next-state logic for the sequencer, HI/LO and the output pulses
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        dsr_d       = dsr_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
`ifdef MULDIV_SIGNED_EN
        is_div_d    = is_div_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    case (funct)
                        F_MFHI: begin
                            out_d       = hi_q;
                            out_valid_d = 1'b1;
                        end
                        F_MFLO: begin
                            out_d       = lo_q;
                            out_valid_d = 1'b1;
                        end
                        F_MTHI: hi_d = a;
                        F_MTLO: lo_d = a;
                        F_MULT, F_MULTU: begin
                            acc_d   = {{WIDTH{1'b0}}, b_mag};
                            dsr_d   = a_mag;
                            cnt_d   = '0;
                            state_d = S_MUL;
`ifdef MULDIV_SIGNED_EN
                            is_div_d  = 1'b0;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = 1'b0;
`endif
                        end
                        F_DIV, F_DIVU: begin
                            if (b == '0) begin
                                // Divide by zero skips the iterations. FIX then
                                // publishes hi=a, lo=all ones with no sign fixup.
                                acc_d   = {a, {WIDTH{1'b1}}};
                                state_d = S_FIX;
`ifdef MULDIV_SIGNED_EN
                                is_div_d  = 1'b1;
                                neg_res_d = 1'b0;
                                neg_rem_d = 1'b0;
`endif
                            end else begin
                                acc_d   = {{WIDTH{1'b0}}, a_mag};
                                dsr_d   = b_mag;
                                cnt_d   = '0;
                                state_d = S_DIV;
`ifdef MULDIV_SIGNED_EN
                                is_div_d  = 1'b1;
                                neg_res_d = a_neg ^ b_neg;
                                neg_rem_d = a_neg;
`endif
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                // The only place where a mul/div result reaches HI/LO
`ifdef MULDIV_SIGNED_EN
                if (is_div_q) begin
                    hi_d = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
                    lo_d = cond_neg(acc_q[WIDTH-1:0], neg_res_q);
                end else begin
                    {hi_d, lo_d} = cond_neg_wide(acc_q, neg_res_q);
                end
`else
                {hi_d, lo_d} = acc_q;
`endif
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and architectural registers. Reset aborts any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            is_div_q    <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
`ifdef MULDIV_SIGNED_EN
            is_div_q    <= is_div_d;
            neg_res_q   <= neg_res_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    // Datapath working registers, with no reset
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        dsr_q <= dsr_d;
    end

    assign ready_out = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer. Every expected value is worked out by hand.
// Where the result depends on the build, MULDIV_SIGNED_EN selects which expected
// value is used.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_in = 1'b0;
    logic         ready_out;
    logic [5:0]   funct = 6'h0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] out;
    logic         out_valid;

    int checks = 0;
    int failures = 0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .funct     (funct),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one op and hold it for exactly one accept edge. Afterwards we are
    // sitting #1 after that edge.
    task automatic issue(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv);
        int n = 0;
        while (!ready_out && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("issue_ready", ready_out, 1);
        valid_in = 1'b1;
        funct    = f;
        a        = av;
        b        = bv;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    // Run a mul/div op. The task checks the latency to done, that HI/LO stay
    // unchanged mid-flight, the final HI/LO, and that done lasts a single cycle.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input int exp_lat,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        logic [W-1:0] old_hi;
        logic [W-1:0] old_lo;
        int lat = 0;
        old_hi = hi;
        old_lo = lo;
        issue(f, av, bv);
        while (!done && lat < 100) begin
            if (lat == 16) begin
                check({tag, "_mid_hi"}, hi, old_hi);
                check({tag, "_mid_lo"}, lo, old_lo);
                check({tag, "_mid_busy"}, busy, 1);
                check({tag, "_mid_ready"}, ready_out, 0);
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        @(posedge clk); #1;
        check({tag, "_done_1cyc"}, done, 0);
    endtask

    initial begin
        int n;
        int seen;
        logic [W-1:0] exp_hi;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_out", out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_ready", ready_out, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // MTHI / MTLO update on the cycle after accept, with no done pulse
        issue(6'h11, 32'hDEADBEEF, 32'h0);
        check("mthi_hi", hi, 32'hDEADBEEF);
        check("mthi_nodone", done, 0);
        issue(6'h13, 32'h0BADF00D, 32'h0);
        check("mtlo_lo", lo, 32'h0BADF00D);

        // MFHI / MFLO return their value one cycle after accept, as a single pulse
        issue(6'h10, 32'h0, 32'h0);
        check("mfhi_vld", out_valid, 1);
        check("mfhi_out", out, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("mfhi_vld_pulse", out_valid, 0);
        issue(6'h12, 32'h0, 32'h0);
        check("mflo_vld", out_valid, 1);
        check("mflo_out", out, 32'h0BADF00D);

        // An unlisted funct is accepted and has no effect
        issue(6'h20, 32'h55, 32'h66);
        check("bad_hi", hi, 32'hDEADBEEF);
        check("bad_lo", lo, 32'h0BADF00D);
        check("bad_vld", out_valid, 0);
        check("bad_done", done, 0);
        check("bad_ready", ready_out, 1);

        // Multiply / divide vectors
        run_op("multu_ff_2", 6'h19, 32'hFFFFFFFF, 32'd2, 33, 32'h00000001, 32'hFFFFFFFE);
`ifdef MULDIV_SIGNED_EN
        run_op("mult_m3_7", 6'h18, 32'hFFFFFFFD, 32'd7, 33, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("div_m7_2", 6'h1A, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_min_m1", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000);
`else
        run_op("mult_m3_7", 6'h18, 32'hFFFFFFFD, 32'd7, 33, 32'h00000006, 32'hFFFFFFEB);
        run_op("div_m7_2", 6'h1A, 32'hFFFFFFF9, 32'd2, 33, 32'h00000001, 32'h7FFFFFFC);
        run_op("div_min_m1", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'h0);
`endif
        run_op("divu_100_7", 6'h1B, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        run_op("divu_5_0", 6'h1B, 32'd5, 32'd0, 1, 32'd5, 32'hFFFFFFFF);
        run_op("mult_min_min", 6'h18, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h0);
        run_op("multu_max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001);

        // MFHI issued right behind a MULT stalls until done and then returns the new HI
`ifdef MULDIV_SIGNED_EN
        exp_hi = 32'hFFFFFFFF;
`else
        exp_hi = 32'h00000006;
`endif
        issue(6'h18, 32'hFFFFFFFD, 32'd7);
        valid_in = 1'b1;
        funct    = 6'h10;
        check("stall_ready0", ready_out, 0);
        n = 0;
        while (!ready_out && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_cycles", n, 33);
        check("stall_done", done, 1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        check("stall_vld", out_valid, 1);
        check("stall_out", out, exp_hi);

        // Reset in the middle of a divide aborts it cleanly
        issue(6'h1B, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", ready_out, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("abort_nodone", seen, 0);
        issue(6'h13, 32'h1234, 32'h0);
        check("abort_mtlo", lo, 32'h1234);
        check("abort_mtlo_hi", hi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
